// File: rtl/reg_op_pkg.sv
// Shared types and sizing for the register-operation engine: op encoding,
// FSM states and default widths.
package reg_op_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 3;
    localparam int INSTR_W = 12;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_CMP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // CMP only updates flags; every other op writes its destination register.
    function automatic logic op_writes_rd(input op_e op);
        return (op != OP_CMP);
    endfunction

endpackage

// File: rtl/reg_op_alu.sv
// Combinational ALU: result, carry/borrow and zero for one decoded op.
module reg_op_alu #(
    parameter int DATA_W = reg_op_pkg::DATA_W
) (
    input  reg_op_pkg::op_e    op,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    output logic [DATA_W-1:0]  result,
    output logic               carry,
    output logic               zero
);
    import reg_op_pkg::*;

    logic [DATA_W:0] ext;

    always_comb begin
        ext    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[DATA_W-1:0];
                carry  = ext[DATA_W];
            end
            // The top bit of the extended difference is the borrow (a < b).
            OP_SUB, OP_CMP: begin
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[DATA_W-1:0];
                carry  = ext[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/reg_op_engine.sv
// Four-state register-operation engine: fetch two operands from an external
// register file, run them through the ALU and write back, one op per 4 cycles.
module reg_op_engine #(
    parameter int DATA_W = reg_op_pkg::DATA_W,
    parameter int ADDR_W = reg_op_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [11:0]        instr,
    output logic               instr_ready,
    output logic [ADDR_W-1:0]  read_port_1,
    output logic [ADDR_W-1:0]  read_port_2,
    input  logic [DATA_W-1:0]  read_data_1,
    input  logic [DATA_W-1:0]  read_data_2,
    output logic [ADDR_W-1:0]  write_port_1,
    output logic [DATA_W-1:0]  write_data,
    output logic               write_enable,
    output logic               done,
    output logic               flag_z,
    output logic               flag_c
);
    import reg_op_pkg::*;

    state_e              state_q, state_d;
    logic [11:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   write_port_1_q, write_port_1_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                write_enable_q, write_enable_d;
    logic                done_q, done_d;
    logic                flag_z_q, flag_z_d;
    logic                flag_c_q, flag_c_d;
    logic                next_z_q, next_z_d;
    logic                next_c_q, next_c_d;

    op_e                 op;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic                alu_zero;
    logic                ports_active;

    assign op = op_e'(instr_q[11:9]);

    reg_op_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (read_data_1),
        .b      (read_data_2),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Read addresses come straight from the latched instruction, so they are
    // valid for the whole of READ and EXEC and forced to zero elsewhere.
    assign ports_active = (state_q == ST_READ) || (state_q == ST_EXEC);
    assign read_port_1  = ports_active ? ADDR_W'(instr_q[5:3]) : '0;
    assign read_port_2  = ports_active ? ADDR_W'(instr_q[2:0]) : '0;

    assign instr_ready  = (state_q == ST_IDLE);
    assign write_port_1 = write_port_1_q;
    assign write_data   = write_data_q;
    assign write_enable = write_enable_q;
    assign done         = done_q;
    assign flag_z       = flag_z_q;
    assign flag_c       = flag_c_q;

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        write_port_1_d = write_port_1_q;
        write_data_d   = write_data_q;
        write_enable_d = 1'b0;
        done_d         = 1'b0;
        flag_z_d       = flag_z_q;
        flag_c_d       = flag_c_q;
        next_z_d       = next_z_q;
        next_c_d       = next_c_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            // Operands arrive here, one cycle after the addresses were issued.
            ST_EXEC: begin
                write_data_d   = alu_result;
                write_port_1_d = ADDR_W'(instr_q[8:6]);
                write_enable_d = op_writes_rd(op);
                done_d         = 1'b1;
                next_z_d       = alu_zero;
                next_c_d       = alu_carry;
                state_d        = ST_WRITE;
            end
            ST_WRITE: begin
                flag_z_d = next_z_q;
                flag_c_d = next_c_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            instr_q        <= '0;
            write_port_1_q <= '0;
            write_data_q   <= '0;
            write_enable_q <= 1'b0;
            done_q         <= 1'b0;
            flag_z_q       <= 1'b0;
            flag_c_q       <= 1'b0;
            next_z_q       <= 1'b0;
            next_c_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            write_port_1_q <= write_port_1_d;
            write_data_q   <= write_data_d;
            write_enable_q <= write_enable_d;
            done_q         <= done_d;
            flag_z_q       <= flag_z_d;
            flag_c_q       <= flag_c_d;
            next_z_q       <= next_z_d;
            next_c_q       <= next_c_d;
        end
    end

endmodule
